// File: rtl/opamp_macro_pkg.sv
// Shared types, width constants and the saturating clamp for the op-amp macromodel.
package opamp_macro_pkg;

  localparam int PKG_W  = 16;
  localparam int PKG_GW = 12;
  localparam int DW     = PKG_W + 1;
  localparam int TW     = PKG_W + 1 + PKG_GW;
  // Working width of the lane: room for the gain product plus one more difference.
  localparam int CLW    = TW + DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic logic signed [CLW-1:0] sat_clamp(
    input logic signed [CLW-1:0] value,
    input logic signed [CLW-1:0] lo,
    input logic signed [CLW-1:0] hi
  );
    logic signed [CLW-1:0] r;
    if (value < lo) begin
      r = lo;
    end else if (value > hi) begin
      r = hi;
    end else begin
      r = value;
    end
    return r;
  endfunction

endpackage

// File: rtl/opamp_macro_lane.sv
// Combinational single-channel step: gain, rail clamp, single pole, slew limit, output clamp.
module opamp_macro_lane
  import opamp_macro_pkg::*;
#(
  parameter int W          = PKG_W,
  parameter int GW         = PKG_GW,
  parameter int POLE_SHIFT = 4,
  parameter int SLEW       = 1024,
  parameter int VSAT       = 30000
) (
  input  logic signed [W-1:0]  in_p,
  input  logic signed [W-1:0]  in_n,
  input  logic        [GW-1:0] gain,
  input  logic signed [W-1:0]  y_cur,
  output logic signed [W-1:0]  y_next,
  output logic                 sat
);

  localparam logic signed [CLW-1:0] V_HI = CLW'(VSAT);
  localparam logic signed [CLW-1:0] V_LO = -V_HI;
  localparam logic signed [CLW-1:0] S_HI = CLW'(SLEW);
  localparam logic signed [CLW-1:0] S_LO = -S_HI;

  logic signed [CLW-1:0] p_ext_s, n_ext_s, g_ext_s, y_ext_s;
  logic signed [CLW-1:0] d_s, t_raw_s, t_s, p_s, s_s, y_new_s;

  // Per-sample datapath, evaluated wide enough that nothing wraps before a clamp.
  always_comb begin
    p_ext_s = {{(CLW-W){in_p[W-1]}}, in_p};
    n_ext_s = {{(CLW-W){in_n[W-1]}}, in_n};
    g_ext_s = {{(CLW-GW){1'b0}}, gain};
    y_ext_s = {{(CLW-W){y_cur[W-1]}}, y_cur};
    d_s     = p_ext_s - n_ext_s;
    t_raw_s = d_s * g_ext_s;
    t_s     = sat_clamp(t_raw_s, V_LO, V_HI);
    p_s     = (t_s - y_ext_s) >>> POLE_SHIFT;
    s_s     = sat_clamp(p_s, S_LO, S_HI);
    y_new_s = sat_clamp(y_ext_s + s_s, V_LO, V_HI);
    y_next  = W'(y_new_s);
    sat     = (t_s != t_raw_s) || (p_s != s_s);
  end

endmodule

// File: rtl/opamp_macro_tdm.sv
// Multi-channel op-amp macromodel: one shared lane walked over the channels per frame.
module opamp_macro_tdm
  import opamp_macro_pkg::*;
#(
  parameter int CH         = 4,
  parameter int W          = PKG_W,
  parameter int GW         = PKG_GW,
  parameter int POLE_SHIFT = 4,
  parameter int SLEW       = 1024,
  parameter int VSAT       = 30000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [GW-1:0]   gain,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] in_p,
  input  logic [CH*W-1:0] in_n,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*W-1:0] out_y,
  output logic [CH-1:0]   out_sat
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [CH*W-1:0]     in_p_q, in_p_d, in_n_q, in_n_d;
  logic [GW-1:0]       gain_q, gain_d;
  logic signed [W-1:0] y_q [CH];
  logic signed [W-1:0] y_d [CH];
  logic [CH-1:0]       sat_acc_q, sat_acc_d, out_sat_q, out_sat_d;
  logic [CH*W-1:0]     out_y_q, out_y_d;
  logic                in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic signed [W-1:0] lane_p_s, lane_n_s, lane_y_s, lane_y_next_s;
  logic                lane_sat_s;

  assign lane_p_s = in_p_q[ch_q*W +: W];
  assign lane_n_s = in_n_q[ch_q*W +: W];
  assign lane_y_s = y_q[ch_q];

  opamp_macro_lane #(
    .W(W), .GW(GW), .POLE_SHIFT(POLE_SHIFT), .SLEW(SLEW), .VSAT(VSAT)
  ) u_lane (
    .in_p   (lane_p_s),
    .in_n   (lane_n_s),
    .gain   (gain_q),
    .y_cur  (lane_y_s),
    .y_next (lane_y_next_s),
    .sat    (lane_sat_s)
  );

  // Next-state logic: capture, per-channel walk, then hold the frame until taken.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    in_p_d      = in_p_q;
    in_n_d      = in_n_q;
    gain_d      = gain_q;
    y_d         = y_q;
    sat_acc_d   = sat_acc_q;
    out_y_d     = out_y_q;
    out_sat_d   = out_sat_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in_p_d     = in_p;
          in_n_d     = in_n;
          gain_d     = gain;
          sat_acc_d  = '0;
          ch_d       = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      CALC: begin
        y_d[ch_q]       = lane_y_next_s;
        sat_acc_d[ch_q] = lane_sat_s;
        if (ch_q == CW'(CH - 1)) begin
          // Outputs change only here, so they stay frozen for the whole hold.
          for (int k = 0; k < CH; k++) begin
            out_y_d[k*W +: W] = y_d[k];
          end
          out_sat_d   = sat_acc_d;
          out_valid_d = 1'b1;
          ch_d        = '0;
          state_d     = HOLD;
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset also drops any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      in_p_q      <= '0;
      in_n_q      <= '0;
      gain_q      <= '0;
      y_q         <= '{default: '0};
      sat_acc_q   <= '0;
      out_y_q     <= '0;
      out_sat_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      in_p_q      <= in_p_d;
      in_n_q      <= in_n_d;
      gain_q      <= gain_d;
      y_q         <= y_d;
      sat_acc_q   <= sat_acc_d;
      out_y_q     <= out_y_d;
      out_sat_q   <= out_sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_sat   = out_sat_q;

endmodule
